// File: rtl/keypad_code_encoder.sv
// 4x4 matrix keypad scanner with press/release debouncing.
// Emits one registered key code per physical press on a 4-bit code bus (1111 = idle).
module keypad_code_encoder #(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        RELEASE
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       col_reg, col_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       row_lat_reg, row_lat_next;
    logic [3:0]       rs_meta_reg, rs_reg;
    logic [3:0]       key_code_reg, key_code_next;
    logic             key_valid_reg, key_valid_next;
    logic             key_held_reg, key_held_next;

    logic [3:0]       row_low;
    logic             one_low;
    logic [1:0]       row_idx;
    logic [4:0]       map_entry;

    // {valid, code} for a (row, col) position; letter keys are not emitted
    function automatic logic [4:0] map_key(input logic [1:0] r, input logic [1:0] c);
        logic [4:0] res;
        res = 5'b0_1111;
        case ({r, c})
            4'b00_00: res = 5'b1_0001;
            4'b00_01: res = 5'b1_0010;
            4'b00_10: res = 5'b1_0011;
            4'b01_00: res = 5'b1_0100;
            4'b01_01: res = 5'b1_0101;
            4'b01_10: res = 5'b1_0110;
            4'b10_00: res = 5'b1_0111;
            4'b10_01: res = 5'b1_1000;
            4'b10_10: res = 5'b1_1001;
            4'b11_00: res = 5'b1_1101;
            4'b11_01: res = 5'b1_0000;
            4'b11_10: res = 5'b1_1110;
            default:  res = 5'b0_1111;
        endcase
        return res;
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col_drive
            assign col_n[gi] = (col_reg != 2'(gi));
        end
    endgenerate

    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_held  = key_held_reg;

    // Exactly one row low; two or more is treated as ghosting and skipped
    assign row_low = ~rs_reg;
    assign one_low = (row_low != 4'b0000) && ((row_low & (row_low - 4'd1)) == 4'b0000);

    always_comb begin
        row_idx = 2'd0;
        case (row_lat_reg)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    assign map_entry = map_key(row_idx, col_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= SCAN;
            col_reg       <= 2'd0;
            div_reg       <= '0;
            cnt_reg       <= '0;
            row_lat_reg   <= 4'b1111;
            rs_meta_reg   <= 4'b1111;
            rs_reg        <= 4'b1111;
            key_code_reg  <= 4'b1111;
            key_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            col_reg       <= col_next;
            div_reg       <= div_next;
            cnt_reg       <= cnt_next;
            row_lat_reg   <= row_lat_next;
            rs_meta_reg   <= row_n;
            rs_reg        <= rs_meta_reg;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            key_held_reg  <= key_held_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        div_next       = div_reg;
        cnt_next       = cnt_reg;
        row_lat_next   = row_lat_reg;
        key_code_next  = 4'b1111;
        key_valid_next = 1'b0;
        key_held_next  = key_held_reg;

        case (state_reg)
            SCAN: begin
                if (div_reg == DIV_LAST) begin
                    div_next = '0;
                    if (one_low) begin
                        row_lat_next = rs_reg;
                        cnt_next     = '0;
                        state_next   = DEBOUNCE;
                    end else begin
                        col_next = col_reg + 2'd1;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rs_reg == row_lat_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next    = EMIT;
                        key_held_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    state_next = SCAN;
                    col_next   = col_reg + 2'd1;
                    div_next   = '0;
                end
            end
            EMIT: begin
                key_valid_next = map_entry[4];
                key_code_next  = map_entry[3:0];
                cnt_next       = '0;
                state_next     = RELEASE;
            end
            RELEASE: begin
                // Column stays driven so the held key keeps its row low until release
                if (rs_reg == 4'b1111) begin
                    if (cnt_reg == CNT_LAST) begin
                        key_held_next = 1'b0;
                        state_next    = SCAN;
                        col_next      = col_reg + 2'd1;
                        div_next      = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            default: state_next = SCAN;
        endcase
    end

endmodule

// File: tb/tb_keypad_code_encoder.sv
// Directed bench for keypad_code_encoder with a passive 4x4 keypad model (SCAN_DIV=4, DEBOUNCE_CYCLES=8).
module tb_keypad_code_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;          // bit r*4+c = key at (row r, col c) is down
    logic [3:0]  pulses[$];
    int          idle_bad = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    keypad_code_encoder #(
        .SCAN_DIV       (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulses.push_back(key_code);
            $display("emit key_code=%b at %0t", key_code, $time);
        end
        if (key_valid == (key_code == 4'b1111)) idle_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_col(input logic [3:0] target);
        int g;
        g = 0;
        while (col_n == target && g < 100) begin tick(1); g++; end
        while (col_n != target && g < 100) begin tick(1); g++; end
        if (g >= 100) check("col_wait_timeout", 1, 0);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!key_valid && lat < 100) begin tick(1); lat++; end
        if (lat >= 100) check("valid_timeout", 1, 0);
    endtask

    task automatic release_idle();
        int g;
        pressed = 16'h0;
        g = 0;
        while (key_held && g < 200) begin tick(1); g++; end
        if (g >= 200) check("release_timeout", 1, 0);
        tick(20);
    endtask

    task automatic press_hold(input logic [15:0] mask, input int hold);
        pressed = mask;
        tick(hold);
        release_idle();
    endtask

    logic [3:0] col_seq[4];
    int         lat;

    initial begin
        col_seq[0] = 4'b1101; col_seq[1] = 4'b1011;
        col_seq[2] = 4'b0111; col_seq[3] = 4'b1110;
        pressed = 16'h0;
        rst_n   = 1'b0;

        // 1. reset values and idle column rotation
        tick(3);
        check("rst_col_n", col_n, 4'b1110);
        check("rst_key_code", key_code, 4'b1111);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_held", key_held, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(3);
            check($sformatf("scan_hold_%0d", k), col_n, (k == 0) ? 4'b1110 : col_seq[k-1]);
            tick(1);
            check($sformatf("scan_step_%0d", k), col_n, col_seq[k]);
        end
        check("t1_no_pulse", pulses.size(), 0);

        // 2. '5' pressed right as column 1 starts: sample on 4th edge, valid 9 edges later
        wait_col(4'b1101);
        pulses.delete();
        pressed = 16'h1 << 5;
        wait_valid(lat);
        check("t2_latency", lat, 13);
        tick(200 - lat);
        check("t2_held", key_held, 1);
        pressed = 16'h0;
        tick(9);
        check("t2_held_before_rel", key_held, 1);
        tick(1);
        check("t2_held_cleared", key_held, 0);
        check("t2_count", pulses.size(), 1);
        check("t2_code", pulses[0], 4'b0101);
        tick(20);

        // 3. '*', '#', '0'
        pulses.delete();
        press_hold(16'h1 << 12, 50);
        press_hold(16'h1 << 14, 50);
        press_hold(16'h1 << 13, 50);
        check("t3_count", pulses.size(), 3);
        check("t3_star", pulses[0], 4'b1101);
        check("t3_hash", pulses[1], 4'b1110);
        check("t3_zero", pulses[2], 4'b0000);

        // 4. bouncing '7', then stable
        pulses.delete();
        for (int k = 0; k < 14; k++) begin
            pressed = (k % 2 == 0) ? (16'h1 << 8) : 16'h0;
            tick(3);
        end
        check("t4_bounce_quiet", pulses.size(), 0);
        pressed = 16'h1 << 8;
        wait_valid(lat);
        tick(30);
        release_idle();
        check("t4_count", pulses.size(), 1);
        check("t4_code", pulses[0], 4'b0111);

        // 5. letter key and ghosted pair give nothing; scanner still responsive
        pulses.delete();
        press_hold(16'h1 << 3, 100);
        check("t5_letter_quiet", pulses.size(), 0);
        press_hold((16'h1 << 0) | (16'h1 << 4), 100);
        check("t5_ghost_quiet", pulses.size(), 0);
        press_hold(16'h1 << 1, 60);
        check("t5_recover_count", pulses.size(), 1);
        check("t5_recover_code", pulses[0], 4'b0010);

        // 6. reset during debounce of '9', key kept held through reset
        wait_col(4'b1011);
        pulses.delete();
        pressed = 16'h1 << 10;
        tick(6);
        rst_n = 1'b0;
        tick(1);
        check("t6_rst_col_n", col_n, 4'b1110);
        check("t6_rst_valid", key_valid, 0);
        check("t6_rst_held", key_held, 0);
        tick(1);
        rst_n = 1'b1;
        check("t6_no_abort_pulse", pulses.size(), 0);
        tick(100);
        check("t6_count", pulses.size(), 1);
        check("t6_code", pulses[0], 4'b1001);
        release_idle();

        check("code_bus_idle_rule", idle_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
